// File: rtl/button_debounce_bank_pkg.sv
// Shared constants for the board push-button debouncer.
// Bit indices follow the GPIO read word {btnC, btnD, btnL, btnR, btnU}.
package btn_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_CNT_W           = 24;
  localparam int NUM_BOARD_BTN           = 5;

  localparam int BTN_U = 0;
  localparam int BTN_R = 1;
  localparam int BTN_L = 2;
  localparam int BTN_D = 3;
  localparam int BTN_C = 4;

endpackage

// File: rtl/button_debounce_bank_if.sv
// Button bank signal bundle: raw pins in, debounced level and edge pulses out.
// No handshake: btn_level is a plain level, btn_rise/btn_fall are one-cycle strobes.
interface button_debounce_bank_if #(
  parameter int NUM_BTN = 5
);

  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_fall;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_rise,
    input  btn_fall
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_rise,
    output btn_fall
  );

endinterface

// File: rtl/button_debounce_bank_channel.sv
// One debounce channel: 2-flop synchronizer, stability counter, accepted level
// and registered rise/fall strobes coincident with the first cycle of a new level.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  wire w_differs = (r_s2 != r_level);
  wire w_accept  = w_differs && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      // Any return to the accepted level restarts qualification from zero.
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (!w_accept) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_level <= r_s2;
        r_cnt   <= '0;
        r_rise  <= r_s2;
        r_fall  <= !r_s2;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of independent debounce channels feeding the GPIO button word.
module button_debounce_bank
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BOARD_BTN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input logic                    clk,
  input logic                    resetn,
  button_debounce_bank_if.slave  bus
);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_fall;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk     (clk),
      .resetn  (resetn),
      .i_btn   (bus.btn_in[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  assign bus.btn_level = w_level;
  assign bus.btn_rise  = w_rise;
  assign bus.btn_fall  = w_fall;

endmodule

// File: tb/tb_button_debounce_bank.sv
// Bench for button_debounce_bank with a short debounce window and a window-based reference model.
module tb_button_debounce_bank;

  localparam int NB = 5;
  localparam int D  = 4;

  logic clk;
  logic resetn;

  button_debounce_bank_if #(.NUM_BTN(NB)) bus ();

  button_debounce_bank #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a level flips at an edge when the last D synchronized
  // samples (all taken after the previous flip/reset) disagree with it.
  logic [NB-1:0] raw_q[$];
  logic [NB-1:0] sync_q[$];
  int            m_edge;
  int            m_last[NB];
  logic [NB-1:0] exp_level = '0;
  logic [NB-1:0] exp_rise  = '0;
  logic [NB-1:0] exp_fall  = '0;
  logic [NB-1:0] m_s;
  logic          m_ok;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      raw_q.delete();
      sync_q.delete();
      m_edge = 0;
      for (int c = 0; c < NB; c++) m_last[c] = -1;
      exp_level = '0;
      exp_rise  = '0;
      exp_fall  = '0;
    end else begin
      m_s = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : '0;
      sync_q.push_back(m_s);
      exp_rise = '0;
      exp_fall = '0;
      for (int c = 0; c < NB; c++) begin
        if (m_edge - m_last[c] >= D) begin
          m_ok = 1'b1;
          for (int j = 0; j < D; j++)
            if (sync_q[m_edge-j][c] == exp_level[c]) m_ok = 1'b0;
          if (m_ok) begin
            exp_level[c] = ~exp_level[c];
            exp_rise[c]  = exp_level[c];
            exp_fall[c]  = ~exp_level[c];
            m_last[c]    = m_edge;
          end
        end
      end
      raw_q.push_back(bus.btn_in);
      m_edge++;
    end
  end

  task automatic test_reset();
    resetn = 1'b1;
    bus.btn_in = '0;
    #1 resetn = 1'b0;
    bus.btn_in = '1;
    #1;
    checks++;
    if ({bus.btn_level, bus.btn_rise, bus.btn_fall} !== 15'b0) begin
      errors++;
      $display("FAIL reset_async got %b/%b/%b exp all 0", bus.btn_level, bus.btn_rise, bus.btn_fall);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({bus.btn_level, bus.btn_rise, bus.btn_fall} !== 15'b0) begin
        errors++;
        $display("FAIL reset_hold got %b/%b/%b exp all 0", bus.btn_level, bus.btn_rise, bus.btn_fall);
      end
    end
    resetn = 1'b1;
    bus.btn_in = '0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({bus.btn_level, bus.btn_rise, bus.btn_fall} !== {exp_level, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL reset_release got %b/%b/%b exp %b/%b/%b", bus.btn_level, bus.btn_rise, bus.btn_fall, exp_level, exp_rise, exp_fall);
      end
    end
  endtask

  task automatic test_clean_press();
    bus.btn_in[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.btn_level[0] !== (i >= D+2) || bus.btn_rise[0] !== (i == D+2) || bus.btn_fall !== '0) begin
        errors++;
        $display("FAIL clean_press edge %0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=0", i, bus.btn_level[0], bus.btn_rise[0], bus.btn_fall, i >= D+2, i == D+2);
      end
      checks++;
      if ({bus.btn_level, bus.btn_rise, bus.btn_fall} !== {exp_level, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL clean_press_model got %b/%b/%b exp %b/%b/%b", bus.btn_level, bus.btn_rise, bus.btn_fall, exp_level, exp_rise, exp_fall);
      end
    end
  endtask

  task automatic test_glitch();
    bus.btn_in[2] = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == D-1) bus.btn_in[2] = 1'b0;
      checks++;
      if (bus.btn_level[2] !== 1'b0 || bus.btn_rise !== '0 || bus.btn_fall !== '0) begin
        errors++;
        $display("FAIL glitch cycle %0d got lvl2=%b rise=%b fall=%b exp 0/0/0", i, bus.btn_level[2], bus.btn_rise, bus.btn_fall);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    int         rises;
    pat   = 5'b10101;
    rises = 0;
    for (int i = 0; i < 5; i++) begin
      bus.btn_in[4] = pat[i];
      @(negedge clk);
      rises += int'(bus.btn_rise[4]);
      checks++;
      if (bus.btn_level[4] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_hold step %0d got lvl4=%b exp 0", i, bus.btn_level[4]);
      end
    end
    // the final 1 was driven before the last loop edge, which is edge 1 of the settle
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      rises += int'(bus.btn_rise[4]);
      checks++;
      if (bus.btn_level[4] !== (i >= D+2) || bus.btn_rise[4] !== (i == D+2)) begin
        errors++;
        $display("FAIL bounce_settle edge %0d got lvl4=%b rise4=%b exp %b/%b", i, bus.btn_level[4], bus.btn_rise[4], i >= D+2, i == D+2);
      end
    end
    checks++;
    if (rises !== 1) begin
      errors++;
      $display("FAIL bounce_rise_count got %0d exp 1", rises);
    end
  endtask

  task automatic test_release();
    bus.btn_in[1] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if ({bus.btn_level, bus.btn_rise, bus.btn_fall} !== {exp_level, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL release_setup got %b/%b/%b exp %b/%b/%b", bus.btn_level, bus.btn_rise, bus.btn_fall, exp_level, exp_rise, exp_fall);
      end
    end
    bus.btn_in[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.btn_level[1] !== (i < D+2) || bus.btn_fall[1] !== (i == D+2) || bus.btn_rise[1] !== 1'b0) begin
        errors++;
        $display("FAIL release edge %0d got lvl1=%b fall1=%b rise1=%b exp %b/%b/0", i, bus.btn_level[1], bus.btn_fall[1], bus.btn_rise[1], i < D+2, i == D+2);
      end
    end
  endtask

  task automatic test_multi_and_reset();
    bus.btn_in = '0;
    repeat (12) @(negedge clk);
    bus.btn_in = 5'b01001;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.btn_rise[3], bus.btn_rise[0]} !== {2{i == D+2}} || {bus.btn_level[3], bus.btn_level[0]} !== {2{i >= D+2}}) begin
        errors++;
        $display("FAIL multi edge %0d got rise=%b lvl=%b exp both %b/%b", i, bus.btn_rise, bus.btn_level, i == D+2, i >= D+2);
      end
    end
    bus.btn_in = '0;
    repeat (12) @(negedge clk);
    bus.btn_in = 5'b01001;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.btn_level, bus.btn_rise, bus.btn_fall} !== 15'b0) begin
      errors++;
      $display("FAIL midcount_reset got %b/%b/%b exp all 0", bus.btn_level, bus.btn_rise, bus.btn_fall);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.btn_level !== (i >= D+2 ? 5'b01001 : 5'b0) || bus.btn_rise !== (i == D+2 ? 5'b01001 : 5'b0)) begin
        errors++;
        $display("FAIL after_reset edge %0d got lvl=%b rise=%b exp lvl_on=%b rise_on=%b", i, bus.btn_level, bus.btn_rise, i >= D+2, i == D+2);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 120; seg++) begin
      bus.btn_in = NB'($urandom_range(0, (1 << NB) - 1));
      hold = $urandom_range(1, 2*D+2);
      if (seg == 60) begin
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end
      repeat (hold) begin
        @(negedge clk);
        checks++;
        if ({bus.btn_level, bus.btn_rise, bus.btn_fall} !== {exp_level, exp_rise, exp_fall}) begin
          errors++;
          $display("FAIL random seg %0d got %b/%b/%b exp %b/%b/%b", seg, bus.btn_level, bus.btn_rise, bus.btn_fall, exp_level, exp_rise, exp_fall);
        end
        checks++;
        if ((bus.btn_rise & bus.btn_fall) !== '0) begin
          errors++;
          $display("FAIL rise_fall_overlap got %b exp 0", bus.btn_rise & bus.btn_fall);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_release();
    test_multi_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
